// File: rtl/angle_reduce_pkg.sv
// Shared widths and Q16.16 angle constants for the angle range-reduction stage.
// Constants are rounded to nearest for FLOAT_BITS=32, FLOAT_DCM_BITS=16.
package angle_reduce_pkg;

  localparam int unsigned FLOAT_BITS     = 32;
  localparam int unsigned FLOAT_DCM_BITS = 16;

  localparam logic [FLOAT_BITS-1:0] PI            = 32'd205887;
  localparam logic [FLOAT_BITS-1:0] HALF_PI       = 32'd102944;
  localparam logic [FLOAT_BITS-1:0] THREE_HALF_PI = 32'd308831;
  localparam logic [FLOAT_BITS-1:0] TWO_PI        = 32'd411775;

endpackage

// File: rtl/angle_fold.sv
// Combinational fold of a reduced magnitude plus sign into [-pi/2, pi/2].
// AddHalfPi shifts the angle by +pi/2 first, giving the sin-domain argument for cos.
module angle_fold
  import angle_reduce_pkg::*;
#(
  parameter bit AddHalfPi = 1'b0
) (
  input  logic [FLOAT_BITS-1:0] rem_i,
  input  logic                  sign_i,
  output logic [FLOAT_BITS-1:0] theta_o
);

  logic [FLOAT_BITS-1:0] r;

  always_comb begin
    // rem_i is in [0, TWO_PI); a negative angle maps to its positive equivalent.
    r = (sign_i && (rem_i != '0)) ? (TWO_PI - rem_i) : rem_i;
    if (AddHalfPi) begin
      r = r + HALF_PI;
      if (r >= TWO_PI) begin
        r = r - TWO_PI;
      end
    end
    if (r > THREE_HALF_PI) begin
      theta_o = r - TWO_PI;
    end else if (r > HALF_PI) begin
      theta_o = PI - r;
    end else begin
      theta_o = r;
    end
  end

endmodule

// File: rtl/angle_reduce.sv
// Iterative shift-subtract modulo-2pi reducer feeding the sin polynomial.
// Optional macro ANGLE_REDUCE_COS_EN adds out_theta_cos, the matching cos argument.
module angle_reduce
  import angle_reduce_pkg::*;
#(
  parameter int unsigned REDUCE_STEPS = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_BITS-1:0] in_angle,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ANGLE_REDUCE_COS_EN
  output logic [FLOAT_BITS-1:0] out_theta_cos,
`endif
  output logic [FLOAT_BITS-1:0] out_theta
);

  localparam int unsigned KW    = (REDUCE_STEPS > 1) ? $clog2(REDUCE_STEPS) : 1;
  localparam int unsigned WideW = FLOAT_BITS + REDUCE_STEPS;
  localparam logic [KW-1:0] KMax = KW'(REDUCE_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StReduce, StFold, StDone} state_e;

  state_e                state_q, state_d;
  logic [FLOAT_BITS-1:0] rem_q, rem_d;
  logic                  sign_q, sign_d;
  logic [KW-1:0]         k_q, k_d;
  logic [FLOAT_BITS-1:0] theta_q, theta_d;
  logic                  valid_q, valid_d;
  logic [FLOAT_BITS-1:0] fold_theta;
  logic [FLOAT_BITS-1:0] in_abs;
  logic [WideW-1:0]      step_val;

  angle_fold #(
    .AddHalfPi(1'b0)
  ) u_fold_sin (
    .rem_i  (rem_q),
    .sign_i (sign_q),
    .theta_o(fold_theta)
  );

`ifdef ANGLE_REDUCE_COS_EN
  logic [FLOAT_BITS-1:0] cos_q, cos_d;
  logic [FLOAT_BITS-1:0] fold_cos;

  angle_fold #(
    .AddHalfPi(1'b1)
  ) u_fold_cos (
    .rem_i  (rem_q),
    .sign_i (sign_q),
    .theta_o(fold_cos)
  );
`endif

  // Magnitude of the most negative input is 2^(FLOAT_BITS-1), which fits unsigned.
  assign in_abs   = in_angle[FLOAT_BITS-1] ? (~in_angle + 1'b1) : in_angle;
  assign step_val = WideW'(TWO_PI) << k_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (in_valid) state_d = StReduce;
      StReduce: if (k_q == '0) state_d = StFold;
      StFold:   state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rem_d   = rem_q;
    sign_d  = sign_q;
    k_d     = k_q;
    theta_d = theta_q;
    valid_d = valid_q;
`ifdef ANGLE_REDUCE_COS_EN
    cos_d   = cos_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_angle[FLOAT_BITS-1];
          rem_d  = in_abs;
          k_d    = KMax;
        end
      end
      StReduce: begin
        if (WideW'(rem_q) >= step_val) begin
          rem_d = rem_q - FLOAT_BITS'(step_val);
        end
        if (k_q != '0) begin
          k_d = k_q - 1'b1;
        end
      end
      StFold: begin
        theta_d = fold_theta;
        valid_d = 1'b1;
`ifdef ANGLE_REDUCE_COS_EN
        cos_d   = fold_cos;
`endif
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
      theta_q <= '0;
      valid_q <= 1'b0;
`ifdef ANGLE_REDUCE_COS_EN
      cos_q   <= '0;
`endif
    end else begin
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
      theta_q <= theta_d;
      valid_q <= valid_d;
`ifdef ANGLE_REDUCE_COS_EN
      cos_q   <= cos_d;
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = valid_q;
    out_theta = theta_q;
`ifdef ANGLE_REDUCE_COS_EN
    out_theta_cos = cos_q;
`endif
  end

endmodule

// File: tb/tb_angle_reduce.sv
// Directed-vector bench for angle_reduce; define ANGLE_REDUCE_COS_EN to also check out_theta_cos.
module tb_angle_reduce;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_theta;
`ifdef ANGLE_REDUCE_COS_EN
  logic [31:0] out_theta_cos;
`endif

  int n_checks = 0;
  int n_errors = 0;

  angle_reduce #(
    .REDUCE_STEPS(13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_angle     (in_angle),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef ANGLE_REDUCE_COS_EN
    .out_theta_cos(out_theta_cos),
`endif
    .out_theta    (out_theta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one angle, measures latency from the accepting edge, then completes the handshake.
  task automatic run_vec(input string tag, input logic [31:0] angle, input logic [31:0] exp_sin,
                         input logic [31:0] exp_cos, input logic pre_ready);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_angle  = angle;
    out_ready = pre_ready;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd14);
    check({tag, ".theta"}, out_theta, exp_sin);
`ifdef ANGLE_REDUCE_COS_EN
    check({tag, ".cos"}, out_theta_cos, exp_cos);
`else
    if (exp_cos === 32'hx) $display("unused cos expectation");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_theta", out_theta, 32'd0);
`ifdef ANGLE_REDUCE_COS_EN
    check("rst.cos", out_theta_cos, 32'd0);
`endif

    run_vec("zero",    32'd0,          32'd0,          32'd102944,     1'b0);
    run_vec("pi",      32'd205887,     32'd0,          -32'sd102944,   1'b0);
    run_vec("three",   32'd196608,     32'd9279,       -32'sd93665,    1'b1);
    run_vec("neg_one", -32'sd65536,    -32'sd65536,    32'd37408,      1'b0);
    run_vec("wrap10",  32'd4183286,    32'd65536,      32'd37407,      1'b1);
    run_vec("3twopi",  32'd1235325,    32'd0,          32'd102944,     1'b0);
    run_vec("halfpi",  32'd102944,     32'd102944,     -32'sd1,        1'b0);
    run_vec("3halfpi", 32'd308831,     -32'sd102944,   32'd0,          1'b0);
    run_vec("minneg",  32'h8000_0000,  -32'sd77023,    32'd25921,      1'b0);

    // Back-pressure: hold DONE for 5 cycles while offering another angle.
    in_valid = 1'b1;
    in_angle = 32'd196608;
    tick();
    in_angle = 32'd0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      tick();
      seen++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold.valid", 32'(out_valid), 32'd1);
      check("hold.theta", out_theta, 32'd9279);
      check("hold.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold.valid_clr", 32'(out_valid), 32'd0);
    check("hold.idle", 32'(in_ready), 32'd1);
    check("hold.theta_kept", out_theta, 32'd9279);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("hold.no_second", 32'(seen), 32'd0);

    // Reset during REDUCE aborts the in-flight angle.
    in_valid = 1'b1;
    in_angle = 32'd65536;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_theta", out_theta, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort.no_stale", 32'(seen), 32'd0);

    run_vec("post_abort", 32'd196608, 32'd9279, -32'sd93665, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
